reg_file_stim_gen: RTL and testbench
====================================

Name: reg_file_stim_gen

Overview:
- Self-checking stimulus source for the UART register-file testbench; sits directly upstream of the DUT register file and the reg-file scoreboard.
- Drives the DUT write/read ports with an LFSR-driven sequence.
- Keeps a shadow golden array and presents `gold` on the same cycle as the DUT's combinational read data `q`, so the scoreboard can compare them at each posedge.

Parameters:
- D_BIT, 8, data width (1..16)
- W, 3, address width; depth 2^W (1..7)
- SEED, 16'hACE1, LFSR seed; 0 is replaced by 16'h0001
- N_OPS, 64, number of random operations per run (1..65535)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle run request, sampled in IDLE/DONE
- wr_en  out  1  DUT write enable
- w_addr  out  W  DUT write address
- r_addr  out  W  DUT read address
- w_data  out  D_BIT  DUT write data
- gold  out  D_BIT  expected read data, combinational from shadow[r_addr]
- chk_en  out  1  gold is meaningful; scoreboard comparisons are gated by it
- busy  out  1  high in INIT and RUN
- done  out  1  high in DONE

Behaviour:
- Clock and reset: one clock domain. rst low asynchronously forces:
  - state IDLE; LFSR = SEED; op_cnt = 0; shadow array all 0
  - all registered outputs 0, so gold = 0
- State IDLE: outputs idle. start=1 moves to INIT on the next edge.
- State INIT: 2^W cycles, index i = 0..2^W-1.
  - wr_en=1, w_addr=i, r_addr=0, w_data=(i ^ 8'h5A) zero-extended or truncated to D_BIT, chk_en=0.
  - After the last index, go to RUN.
- State RUN: N_OPS cycles.
  - Each cycle the LFSR advances once: lfsr_next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Output registers load from the advanced value: wr_en=l[0], w_addr=l[W:1], r_addr=l[2W:W+1], w_data=l[15:16-D_BIT]. The first RUN cycle therefore uses the value after one shift.
  - chk_en=1. op_cnt increments per RUN cycle; after N_OPS cycles go to DONE.
- State DONE:
  - wr_en=0; addresses and data hold; chk_en=1; done=1; busy=0.
  - start=1 goes to INIT. The LFSR is not reseeded, so the next run continues the sequence.
- start while busy is ignored.
- Shadow array:
  - Written on the same edge as the DUT: shadow[w_addr] <= w_data when wr_en.
  - gold = shadow[r_addr], combinational.
- Read-during-write (wr_en and w_addr==r_addr): gold shows the old value in that cycle and the new value from the next cycle, matching a combinational-read register file.
- Reset mid-operation: immediate return to IDLE with reset values. The next start reproduces the identical sequence from SEED.

Optional Feature:
- Macro: REG_FILE_STIM_FAULT_EN.
- Defined: during the RUN cycle where op_cnt == N_OPS/2, gold bit 0 is inverted for that single cycle only. This proves the scoreboard detects mismatches.
- Not defined: gold is always the exact shadow value. No fault logic is synthesised.

Test Plan:
1. Release rst, pulse start at cycle k -> cycles k+1..k+8 show wr_en=1, w_addr 0..7, w_data 5A,5B,58,59,5E,5F,5C,5D; busy=1, chk_en=0.
2. First RUN cycle (SEED=ACE1, so the LFSR value is 59C3) -> wr_en=1, w_addr=1, r_addr=4, w_data=8'h59, chk_en=1, gold=8'h5E.
3. Full run with an ideal combinational-read reg file and a scoreboard gated by chk_en -> done=1 at cycle k+1+8+64, busy=0, scoreboard errors=0.
4. Cycle with wr_en=1 and w_addr==r_addr -> gold equals the pre-write value in that cycle and equals w_data the cycle after.
5. rst low mid-RUN -> all outputs 0 immediately. A new start reproduces the output trace of test 1 and the first RUN cycle of test 2 bit-exactly.
6. REG_FILE_STIM_FAULT_EN defined, N_OPS=64 -> exactly one mismatch, at op_cnt=32; scoreboard errors=1.

Source files
------------

// File: rtl/reg_file_stim_gen_if.sv
// Bus between the register-file stimulus generator and its consumers
// (DUT register file and scoreboard).
interface reg_file_stim_gen_if #(
  parameter int D_BIT = 8,
  parameter int W     = 3
);
  logic             start;
  logic             wr_en;
  logic [W-1:0]     w_addr;
  logic [W-1:0]     r_addr;
  logic [D_BIT-1:0] w_data;
  logic [D_BIT-1:0] gold;
  logic             chk_en;
  logic             busy;
  logic             done;

  modport master (
    input  start,
    output wr_en, w_addr, r_addr, w_data, gold, chk_en, busy, done
  );

  modport slave (
    output start,
    input  wr_en, w_addr, r_addr, w_data, gold, chk_en, busy, done
  );
endinterface

// File: rtl/reg_file_stim_gen.sv
// LFSR-driven stimulus source for a register file, with a shadow golden copy.
// Optional macro REG_FILE_STIM_FAULT_EN flips gold bit 0 on the middle RUN cycle.
module reg_file_stim_gen #(
  parameter int          D_BIT = 8,
  parameter int          W     = 3,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          N_OPS = 64
) (
  input  logic                clk,
  input  logic                rst,
  reg_file_stim_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_e;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LAST_OP  = 16'(N_OPS - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     idx_q, idx_d;
  logic [15:0]      opCnt_q, opCnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             wrEn_q, wrEn_d;
  logic [W-1:0]     wAddr_q, wAddr_d;
  logic [W-1:0]     rAddr_q, rAddr_d;
  logic [D_BIT-1:0] wData_q, wData_d;
  logic             chkEn_q, chkEn_d;
  logic [D_BIT-1:0] shadow_q [2**W];
  logic [D_BIT-1:0] goldRaw;
  logic [D_BIT-1:0] goldOut;

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opCnt_q <= '0;
      lfsr_q  <= SEED_EFF;
      wrEn_q  <= 1'b0;
      wAddr_q <= '0;
      rAddr_q <= '0;
      wData_q <= '0;
      chkEn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opCnt_q <= opCnt_d;
      lfsr_q  <= lfsr_d;
      wrEn_q  <= wrEn_d;
      wAddr_q <= wAddr_d;
      rAddr_q <= rAddr_d;
      wData_q <= wData_d;
      chkEn_q <= chkEn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opCnt_d = opCnt_q;
    lfsr_d  = lfsr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = INIT;
          idx_d   = '0;
        end
      end
      INIT: begin
        if (idx_q == {W{1'b1}}) begin
          state_d = RUN;
          opCnt_d = '0;
          lfsr_d  = lfsrStep(lfsr_q);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RUN: begin
        if (opCnt_q == LAST_OP) begin
          state_d = DONE;
        end else begin
          opCnt_d = opCnt_q + 16'd1;
          lfsr_d  = lfsrStep(lfsr_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers load from the upcoming state so each value is visible in the cycle it belongs to.
  always_comb begin
    wrEn_d  = 1'b0;
    wAddr_d = wAddr_q;
    rAddr_d = rAddr_q;
    wData_d = wData_q;
    chkEn_d = 1'b0;
    unique case (state_d)
      IDLE: ;
      INIT: begin
        wrEn_d  = 1'b1;
        wAddr_d = idx_d;
        rAddr_d = '0;
        wData_d = D_BIT'({8'h00, 8'h5A ^ 8'(idx_d)});
      end
      RUN: begin
        wrEn_d  = lfsr_d[0];
        wAddr_d = lfsr_d[W:1];
        rAddr_d = lfsr_d[2*W:W+1];
        wData_d = lfsr_d[15:16-D_BIT];
        chkEn_d = 1'b1;
      end
      DONE: chkEn_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**W; i++) shadow_q[i] <= '0;
    end else if (wrEn_q) begin
      shadow_q[wAddr_q] <= wData_q;
    end
  end

  assign goldRaw = shadow_q[rAddr_q];

`ifdef REG_FILE_STIM_FAULT_EN
  localparam logic [15:0]      HALF_OP   = 16'(N_OPS / 2);
  localparam logic [D_BIT-1:0] FLIP_MASK = D_BIT'(1);
  assign goldOut = ((state_q == RUN) && (opCnt_q == HALF_OP)) ? (goldRaw ^ FLIP_MASK) : goldRaw;
`else
  assign goldOut = goldRaw;
`endif

  assign bus.wr_en  = wrEn_q;
  assign bus.w_addr = wAddr_q;
  assign bus.r_addr = rAddr_q;
  assign bus.w_data = wData_q;
  assign bus.gold   = goldOut;
  assign bus.chk_en = chkEn_q;
  assign bus.busy   = (state_q == INIT) || (state_q == RUN);
  assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_reg_file_stim_gen.sv
// Directed bench for reg_file_stim_gen: vector table for INIT/early RUN,
// an ideal register-file scoreboard, and reset/restart sequences.
module tb_reg_file_stim_gen;
  localparam int D_BIT = 8;
  localparam int W     = 3;
  localparam int NVEC  = 12;
`ifdef REG_FILE_STIM_FAULT_EN
  localparam int EXP_SB = 1;
`else
  localparam int EXP_SB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_file_stim_gen_if #(.D_BIT(D_BIT), .W(W)) bus ();

  reg_file_stim_gen #(
    .D_BIT(D_BIT), .W(W), .SEED(16'hACE1), .N_OPS(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             wrEn;
    logic [W-1:0]     wAddr;
    logic [W-1:0]     rAddr;
    logic [D_BIT-1:0] wData;
    logic [D_BIT-1:0] gold;
    logic             chkEn;
    logic             busy;
  } vec_t;

  vec_t vecs [NVEC];
  int   testsRun  = 0;
  int   failCount = 0;
  int   sbErrors  = 0;
  int   cyc;

  // Ideal combinational-read register file used as the scoreboard reference
  logic [D_BIT-1:0] model [2**W];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 2**W; j++) model[j] <= '0;
    end else if (bus.wr_en) begin
      model[bus.w_addr] <= bus.w_data;
    end
  end

  always @(negedge clk) begin
    if (rst && bus.chk_en && (bus.gold !== model[bus.r_addr])) begin
      sbErrors++;
      $display("[TB] scoreboard diff at r_addr=%0d: gold=%0h model=%0h", bus.r_addr, bus.gold, model[bus.r_addr]);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic checkVector(input int i);
    checkOutput($sformatf("vec%0d.wr_en", i),  32'(bus.wr_en),  32'(vecs[i].wrEn));
    checkOutput($sformatf("vec%0d.w_addr", i), 32'(bus.w_addr), 32'(vecs[i].wAddr));
    checkOutput($sformatf("vec%0d.r_addr", i), 32'(bus.r_addr), 32'(vecs[i].rAddr));
    checkOutput($sformatf("vec%0d.w_data", i), 32'(bus.w_data), 32'(vecs[i].wData));
    checkOutput($sformatf("vec%0d.gold", i),   32'(bus.gold),   32'(vecs[i].gold));
    checkOutput($sformatf("vec%0d.chk_en", i), 32'(bus.chk_en), 32'(vecs[i].chkEn));
    checkOutput($sformatf("vec%0d.busy", i),   32'(bus.busy),   32'(vecs[i].busy));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".wr_en"},  32'(bus.wr_en),  32'd0);
    checkOutput({tag, ".w_addr"}, 32'(bus.w_addr), 32'd0);
    checkOutput({tag, ".r_addr"}, 32'(bus.r_addr), 32'd0);
    checkOutput({tag, ".w_data"}, 32'(bus.w_data), 32'd0);
    checkOutput({tag, ".gold"},   32'(bus.gold),   32'd0);
    checkOutput({tag, ".chk_en"}, 32'(bus.chk_en), 32'd0);
    checkOutput({tag, ".busy"},   32'(bus.busy),   32'd0);
    checkOutput({tag, ".done"},   32'(bus.done),   32'd0);
  endtask

  task automatic runVectorTable();
    applyStimulus();
    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) @(negedge clk);
      checkVector(i);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.start = 1'b0;
    // INIT: data = i ^ 5A, gold reads address 0 (old value while address 0 is being written)
    vecs[0]  = '{1'b1, 3'd0, 3'd0, 8'h5A, 8'h00, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 3'd1, 3'd0, 8'h5B, 8'h5A, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 3'd2, 3'd0, 8'h58, 8'h5A, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3'd3, 3'd0, 8'h59, 8'h5A, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 3'd4, 3'd0, 8'h5E, 8'h5A, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 3'd5, 3'd0, 8'h5F, 8'h5A, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 3'd6, 3'd0, 8'h5C, 8'h5A, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 3'd7, 3'd0, 8'h5D, 8'h5A, 1'b0, 1'b1};
    // RUN: LFSR values 59C3, B387, 670F, CE1E
    vecs[8]  = '{1'b1, 3'd1, 3'd4, 8'h59, 8'h5E, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 3'd3, 3'd0, 8'hB3, 8'h5A, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 3'd7, 3'd0, 8'h67, 8'h5A, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 3'd7, 3'd1, 8'hCE, 8'h59, 1'b1, 1'b1};

    #1 rst = 1'b0;
    #20;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle.busy", 32'(bus.busy), 32'd0);

    runVectorTable();

    // Run to completion; a start pulse mid-RUN must be ignored
    cyc = NVEC;
    while (!bus.done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == 30);
    end
    bus.start = 1'b0;
    checkOutput("done_cycle", 32'(cyc), 32'd73);
    checkOutput("done.done",   32'(bus.done),   32'd1);
    checkOutput("done.busy",   32'(bus.busy),   32'd0);
    checkOutput("done.wr_en",  32'(bus.wr_en),  32'd0);
    checkOutput("done.chk_en", 32'(bus.chk_en), 32'd1);

    // Restart from DONE, then reset in the middle of RUN
    applyStimulus();
    checkOutput("restart.wr_en",  32'(bus.wr_en),  32'd1);
    checkOutput("restart.w_addr", 32'(bus.w_addr), 32'd0);
    checkOutput("restart.w_data", 32'(bus.w_data), 32'h5A);
    checkOutput("restart.busy",   32'(bus.busy),   32'd1);
    checkOutput("restart.done",   32'(bus.done),   32'd0);
    repeat (15) @(negedge clk);
    checkOutput("midrun.chk_en", 32'(bus.chk_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst = 1'b1;

    // Sequence after reset must match the first run exactly
    runVectorTable();

    checkOutput("sb_errors", 32'(sbErrors), 32'(EXP_SB));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
